dcache_responder: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache.
- Acts as the responder on the pipeline's data-memory port (read/write/byte_enable/addr/wdata in; rdata/resp out).
- Refills and evicts whole 256-bit lines over a single-beat physical-memory port.
- Hits complete in the request cycle, so the pipeline's cache_stall stays low on hits.

---
 rtl/dcache_types.sv | 33 +++
 rtl/dcache_line_array.sv | 60 ++++++
 rtl/dcache_responder.sv | 189 ++++++++++++++++++
 tb/tb_dcache_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_types.sv
// Shared types, constants and line-manipulation helpers for the L1 data cache.
// Lines are fixed at 32 bytes (eight 32-bit words).
package dcache_types;

    localparam int S_OFFSET  = 5;
    localparam int LINE_BITS = 256;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FETCH
    } dcache_state_t;

    // Extract the 32-bit word selected by addr[4:2] from a line.
    function automatic logic [31:0] word_sel(input logic [LINE_BITS-1:0] line,
                                             input logic [2:0]           word);
        return line[int'(word)*32 +: 32];
    endfunction

    // Return the line with the enabled bytes of wdata written into the selected word.
    function automatic logic [LINE_BITS-1:0] merge_bytes(input logic [LINE_BITS-1:0] line,
                                                         input logic [31:0]          wdata,
                                                         input logic [3:0]           be,
                                                         input logic [2:0]           word);
        logic [LINE_BITS-1:0] merged;
        merged = line;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[int'(word)*32 + b*8 +: 8] = wdata[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Storage for the direct-mapped cache: line data, tags, valid and dirty bits.
// One write port with a per-byte line mask; all reads are combinational.
module dcache_line_array
    import dcache_types::*;
#(
    parameter int S_INDEX = 3,
    parameter int S_TAG   = 32 - S_INDEX - S_OFFSET
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [S_INDEX-1:0]     idx,
    input  logic                   data_we,
    input  logic [LINE_BITS/8-1:0] byte_mask,
    input  logic [LINE_BITS-1:0]   wr_line,
    input  logic                   install,
    input  logic [S_TAG-1:0]       wr_tag,
    input  logic                   dirty_we,
    input  logic                   wr_dirty,
    output logic [LINE_BITS-1:0]   rd_line,
    output logic [S_TAG-1:0]       rd_tag,
    output logic                   rd_valid,
    output logic                   rd_dirty
);

    localparam int SETS = 2**S_INDEX;

    logic [LINE_BITS-1:0] data_q [SETS];
    logic [S_TAG-1:0]     tag_q  [SETS];
    logic [SETS-1:0]      valid_q;
    logic [SETS-1:0]      dirty_q;

    // Data and tag writes: byte-masked line update, tag written when a refill installs the line.
    // NOTE: data and tag arrays have no reset; a cleared valid bit makes stale contents unreachable.
    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (data_we) begin
            for (int b = 0; b < LINE_BITS/8; b++) begin
                if (byte_mask[b]) data_q[idx][b*8 +: 8] <= wr_line[b*8 +: 8];
            end
        end
        if (install) tag_q[idx] <= wr_tag;
    end

    // Valid and dirty bits: cleared asynchronously, set on refill / store, cleared on writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (install)  valid_q[idx] <= 1'b1;
            if (dirty_we) dirty_q[idx] <= wr_dirty;
        end
    end

    assign rd_line  = data_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate L1 data cache on the pipeline data port.
// Hits answer in the request cycle; misses evict (if dirty) then refill whole lines.
// Optional hit/miss counters are built when DCACHE_PERF_CTR_EN is defined.
module dcache_responder
    import dcache_types::*;
#(
    parameter int S_INDEX = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dcache_read,
    input  logic                 dcache_write,
    input  logic [3:0]           dcache_byte_enable,
    input  logic [31:0]          dcache_addr,
    input  logic [31:0]          dcache_wdata,
    output logic [31:0]          dcache_rdata,
    output logic                 dcache_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [31:0]          pmem_addr,
    output logic [LINE_BITS-1:0] pmem_wdata,
    input  logic [LINE_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
`ifdef DCACHE_PERF_CTR_EN
    ,
    output logic [31:0]          perf_hits,
    output logic [31:0]          perf_misses
`endif
);

    localparam int S_TAG = 32 - S_INDEX - S_OFFSET;

    dcache_state_t        state;
    logic [S_INDEX-1:0]   miss_idx;
    logic [S_TAG-1:0]     miss_tag;

    logic                 req;
    logic [S_INDEX-1:0]   req_idx;
    logic [S_TAG-1:0]     req_tag;
    logic [2:0]           req_word;
    logic [S_INDEX-1:0]   arr_idx;
    logic                 hit;

    logic                 data_we;
    logic [LINE_BITS/8-1:0] byte_mask;
    logic [LINE_BITS-1:0] wr_line;
    logic                 install;
    logic                 dirty_we;
    logic                 wr_dirty;
    logic [LINE_BITS-1:0] rd_line;
    logic [S_TAG-1:0]     rd_tag;
    logic                 rd_valid;
    logic                 rd_dirty;

    logic                 unused_addr_bits;
    assign unused_addr_bits = ^dcache_addr[1:0];

    dcache_line_array #(
        .S_INDEX (S_INDEX),
        .S_TAG   (S_TAG)
    ) u_lines (
        .clk       (clk),
        .rst       (rst),
        .idx       (arr_idx),
        .data_we   (data_we),
        .byte_mask (byte_mask),
        .wr_line   (wr_line),
        .install   (install),
        .wr_tag    (miss_tag),
        .dirty_we  (dirty_we),
        .wr_dirty  (wr_dirty),
        .rd_line   (rd_line),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty)
    );

    // Request decode, hit detection and the combinational response path.
    always_comb begin
        req          = dcache_read || dcache_write;
        req_idx      = dcache_addr[S_OFFSET +: S_INDEX];
        req_tag      = dcache_addr[31 -: S_TAG];
        req_word     = dcache_addr[4:2];
        // While a miss is in flight the array stays on the latched set.
        arr_idx      = (state == IDLE) ? req_idx : miss_idx;
        hit          = (state == IDLE) && rd_valid && (rd_tag == req_tag);
        dcache_resp  = req && hit;
        dcache_rdata = word_sel(rd_line, req_word);
        pmem_wdata   = rd_line;
    end

    // Array write control: store merge on a hit, dirty clear on writeback, line install on refill.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        data_we   = 1'b0;
        byte_mask = '0;
        wr_line   = pmem_rdata;
        install   = 1'b0;
        dirty_we  = 1'b0;
        wr_dirty  = 1'b0;
        case (state)
            IDLE: begin
                if (dcache_write && hit) begin
                    data_we   = 1'b1;
                    byte_mask = (LINE_BITS/8)'(dcache_byte_enable) << (int'(req_word) * 4);
                    wr_line   = merge_bytes(rd_line, dcache_wdata, dcache_byte_enable, req_word);
                    dirty_we  = |dcache_byte_enable;
                    wr_dirty  = 1'b1;
                end
            end
            WRITEBACK: begin
                dirty_we = pmem_resp;
            end
            FETCH: begin
                if (pmem_resp) begin
                    data_we   = 1'b1;
                    byte_mask = '1;
                    install   = 1'b1;
                    dirty_we  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Miss FSM with registered memory-port outputs; reset abandons any in-flight transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            pmem_addr  <= '0;
            miss_idx   <= '0;
            miss_tag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req && !hit) begin
                        miss_idx <= req_idx;
                        miss_tag <= req_tag;
                        if (rd_valid && rd_dirty) begin
                            state      <= WRITEBACK;
                            pmem_write <= 1'b1;
                            pmem_addr  <= {rd_tag, req_idx, {S_OFFSET{1'b0}}};
                        end else begin
                            state      <= FETCH;
                            pmem_read  <= 1'b1;
                            pmem_addr  <= {req_tag, req_idx, {S_OFFSET{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state      <= FETCH;
                        pmem_write <= 1'b0;
                        pmem_read  <= 1'b1;
                        pmem_addr  <= {miss_tag, miss_idx, {S_OFFSET{1'b0}}};
                    end
                end
                FETCH: begin
                    if (pmem_resp) begin
                        state     <= IDLE;
                        pmem_read <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_CTR_EN
    // Saturating hit and miss counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else begin
            if (dcache_resp && (perf_hits != 32'hFFFF_FFFF))
                perf_hits <= perf_hits + 32'd1;
            if ((state == IDLE) && req && !hit && (perf_misses != 32'hFFFF_FFFF))
                perf_misses <= perf_misses + 32'd1;
        end
    end
`endif

    // A simultaneous load and store is a pipeline bug; the store path wins.
    assert property (@(posedge clk) disable iff (!rst) !(dcache_read && dcache_write));

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: directed scenarios followed by random
// traffic, checked against a word-level memory view and a per-set tag/dirty model.
module tb_dcache_responder;

    logic         clk = 1'b0;
    logic         rst;
    logic         dcache_read;
    logic         dcache_write;
    logic [3:0]   dcache_byte_enable;
    logic [31:0]  dcache_addr;
    logic [31:0]  dcache_wdata;
    logic [31:0]  dcache_rdata;
    logic         dcache_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_addr;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
`ifdef DCACHE_PERF_CTR_EN
    logic [31:0]  perf_hits;
    logic [31:0]  perf_misses;
`endif

    always #5 clk = ~clk;

    dcache_responder dut (
        .clk                (clk),
        .rst                (rst),
        .dcache_read        (dcache_read),
        .dcache_write       (dcache_write),
        .dcache_byte_enable (dcache_byte_enable),
        .dcache_addr        (dcache_addr),
        .dcache_wdata       (dcache_wdata),
        .dcache_rdata       (dcache_rdata),
        .dcache_resp        (dcache_resp),
        .pmem_read          (pmem_read),
        .pmem_write         (pmem_write),
        .pmem_addr          (pmem_addr),
        .pmem_wdata         (pmem_wdata),
        .pmem_rdata         (pmem_rdata),
        .pmem_resp          (pmem_resp)
`ifdef DCACHE_PERF_CTR_EN
        ,
        .perf_hits          (perf_hits),
        .perf_misses        (perf_misses)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Backing memory (environment) and the CPU-visible memory view (reference).
    logic [31:0] pmem_words [int unsigned];
    logic [31:0] ref_words  [int unsigned];
    // Per-set residency model: which line each set holds and whether it is modified.
    bit          m_valid [8];
    logic [23:0] m_tag   [8];
    bit          m_dirty [8];
    // Completed memory transactions: {is_write, line address}.
    logic [32:0] log_q [$];
    int          mem_lat = 3;
    int          exp_hits = 0;
    int          exp_misses = 0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [31:0] pmem_word(input logic [31:0] a);
        return pmem_words.exists(a) ? pmem_words[a] : init_word(a);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_words.exists(a) ? ref_words[a] : init_word(a);
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Physical memory: answers each read/write after mem_lat cycles with a one-cycle pmem_resp.
    initial begin
        int cnt;
        cnt = 0;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst || pmem_resp) begin
                pmem_resp = 1'b0;
                cnt = 0;
            end else if (pmem_read || pmem_write) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    for (int w = 0; w < 8; w++) begin
                        logic [31:0] wa;
                        wa = pmem_addr + 32'(w * 4);
                        if (pmem_write) pmem_words[wa] = pmem_wdata[w*32 +: 32];
                        else            pmem_rdata[w*32 +: 32] = pmem_word(wa);
                    end
                    log_q.push_back({pmem_write, pmem_addr});
                    pmem_resp = 1'b1;
                end
            end
        end
    end

    // One load or store; called just after a rising edge, returns just after the completing edge.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input string tag);
        int          idx;
        logic [23:0] t;
        bit          hit;
        logic [32:0] exp_log [$];
        int          cycles;
        logic [31:0] wa;
        logic [31:0] w;
        wa  = addr & 32'hFFFF_FFFC;
        idx = int'(addr[7:5]);
        t   = addr[31:8];
        hit = m_valid[idx] && (m_tag[idx] == t);
        if (!hit) begin
            if (m_valid[idx] && m_dirty[idx])
                exp_log.push_back({1'b1, m_tag[idx], 3'(idx), 5'b0});
            exp_log.push_back({1'b0, t, 3'(idx), 5'b0});
            m_valid[idx] = 1'b1;
            m_tag[idx]   = t;
            m_dirty[idx] = 1'b0;
            exp_misses++;
        end
        exp_hits++;
        log_q.delete();
        dcache_addr        = addr;
        dcache_read        = !wr;
        dcache_write       = wr;
        dcache_byte_enable = be;
        dcache_wdata       = wd;
        cycles = 0;
        @(negedge clk);
        while (!dcache_resp && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
        check({tag, " resp"}, 64'(dcache_resp), 64'd1);
        check({tag, " same_cycle_iff_hit"}, 64'(cycles == 0), 64'(hit));
        if (!wr) check({tag, " rdata"}, 64'(dcache_rdata), 64'(ref_word(wa)));
        check({tag, " pmem_txn_count"}, 64'(log_q.size()), 64'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < log_q.size(); i++)
            check({tag, " pmem_txn"}, 64'(log_q[i]), 64'(exp_log[i]));
        @(posedge clk);
        #1;
        if (wr) begin
            w = ref_word(wa);
            for (int b = 0; b < 4; b++)
                if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
            ref_words[wa] = w;
            if (be != 4'b0000) m_dirty[idx] = 1'b1;
        end
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
    endtask

    task automatic check_perf(input string tag);
`ifdef DCACHE_PERF_CTR_EN
        check({tag, " perf_hits"},   64'(perf_hits),   64'(exp_hits));
        check({tag, " perf_misses"}, 64'(perf_misses), 64'(exp_misses));
`else
        if (tag.len() < 0) $display("%s", tag);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        logic [31:0] a;
        rst                = 1'b0;
        dcache_read        = 1'b0;
        dcache_write       = 1'b0;
        dcache_byte_enable = 4'b0000;
        dcache_addr        = 32'h0;
        dcache_wdata       = 32'h0;

        // Reset state, with a load presented while reset is held.
        repeat (2) @(negedge clk);
        dcache_addr = 32'h0000_0104;
        dcache_read = 1'b1;
        #1;
        check("reset resp",       64'(dcache_resp), 64'd0);
        check("reset pmem_read",  64'(pmem_read),   64'd0);
        check("reset pmem_write", 64'(pmem_write),  64'd0);
        check("reset pmem_addr",  64'(pmem_addr),   64'd0);
        check_perf("reset");
        dcache_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Cold read, hit, partial store, read-back.
        pmem_words[32'h104] = 32'hDEAD_BEEF;
        ref_words[32'h104]  = 32'hDEAD_BEEF;
        access(1'b0, 32'h0000_0104, 4'b0000, 32'h0, "cold_read");
        check_perf("cold_read");
        access(1'b0, 32'h0000_0104, 4'b0000, 32'h0, "repeat_read");
        access(1'b1, 32'h0000_0104, 4'b0011, 32'h1234_5678, "store_half");
        access(1'b0, 32'h0000_0104, 4'b0000, 32'h0, "read_merged");

        // Conflict miss on a dirty line: writeback of the old line, then refill.
        access(1'b0, 32'h0000_0904, 4'b0000, 32'h0, "evict_dirty");
        check("evict_dirty wb_word1", 64'(pmem_word(32'h104)), 64'h0000_0000_DEAD_5678);

        // Reset asserted while the refill is outstanding.
        mem_lat     = 10;
        seen        = 1'b0;
        dcache_addr = 32'h0000_0104;
        dcache_read = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = pmem_read;
        end
        check("rst_fetch pmem_read_seen", 64'(seen), 64'd1);
        rst = 1'b0;
        #1;
        check("rst_fetch pmem_read",  64'(pmem_read),  64'd0);
        check("rst_fetch pmem_write", 64'(pmem_write), 64'd0);
        check("rst_fetch pmem_addr",  64'(pmem_addr),  64'd0);
        dcache_read = 1'b0;
        for (int s = 0; s < 8; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
        exp_hits   = 0;
        exp_misses = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mem_lat = 2;
        access(1'b0, 32'h0000_0104, 4'b0000, 32'h0, "post_reset_read");

        // Empty-mask store leaves the line clean: the next eviction does no writeback.
        access(1'b1, 32'h0000_0104, 4'b0000, 32'hFFFF_FFFF, "store_be0");
        access(1'b0, 32'h0000_0904, 4'b0000, 32'h0, "evict_clean");
        access(1'b0, 32'h0000_0104, 4'b0000, 32'h0, "reload_after_be0");

        // Back-to-back hits to different sets.
        access(1'b0, 32'h0000_0124, 4'b0000, 32'h0, "fill_set1");
        access(1'b0, 32'h0000_0104, 4'b0000, 32'h0, "b2b_hit_set0");
        access(1'b0, 32'h0000_0128, 4'b0000, 32'h0, "b2b_hit_set1");
        check_perf("directed");

        // Random traffic over four tags per set to force hits, clean and dirty evictions.
        for (int n = 0; n < 80; n++) begin
            mem_lat = int'($urandom_range(1, 4));
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 5) | ($urandom_range(0, 7) << 2);
            access(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom(), "random");
        end
        check_perf("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
